// File: rtl/ir_status_decoder_if.sv
// IR/status stage bus: control inputs, instruction word, ALU flags in;
// registered IR, class, illegal, status and branch qualifier out.
interface ir_status_decoder_if #(
  parameter int IW = 32
);
  logic          ir_load;
  logic [IW-1:0] ir_data_in;
  logic          flag_load;
  logic [3:0]    alu_flags;
  logic          alu_zero;
  logic          illegal_clear;
  logic [IW-1:0] instruction;
  logic [2:0]    instr_class;
  logic          illegal;
  logic [4:0]    status;
  logic          cond_met;

  modport master (
    output ir_load, ir_data_in, flag_load,
    output alu_flags, alu_zero, illegal_clear,
    input  instruction, instr_class, illegal,
    input  status, cond_met
  );

  modport slave (
    input  ir_load, ir_data_in, flag_load,
    input  alu_flags, alu_zero, illegal_clear,
    output instruction, instr_class, illegal,
    output status, cond_met
  );
endinterface

// File: rtl/ir_status_decoder.sv
// LEGv8 instruction register, opcode class decoder, NZCV flag register
// and B.cond/CBZ/CBNZ evaluation.
// Ports: clock, reset (sync, active-high), bus (ir_status_decoder_if.slave).
module ir_status_decoder #(
  parameter int         IW         = 32,
  parameter logic [3:0] FLAG_RST   = 4'b0000,
  parameter bit         STICKY_ILL = 1'b1
) (
  input logic             clock,
  input logic             reset,
  ir_status_decoder_if.slave bus
);

  localparam logic [2:0] C_NONE = 3'd0;
  localparam logic [2:0] C_D    = 3'd1;
  localparam logic [2:0] C_R    = 3'd2;
  localparam logic [2:0] C_I    = 3'd3;
  localparam logic [2:0] C_B    = 3'd4;
  localparam logic [2:0] C_CB   = 3'd5;
  localparam logic [2:0] C_IW   = 3'd6;

  logic [IW-1:0] ir_q;
  logic [2:0]    cls_q;
  logic          ill_q;
  logic [3:0]    flags_q;

  logic [10:0]   op;
  logic [2:0]    dec_cls;
  logic          dec_ill;

  assign op = bus.ir_data_in[IW-1:IW-11];

  // Ordered patterns: the first hit defines the class.
  always_comb begin
    dec_cls = C_NONE;
    dec_ill = 1'b0;
    priority case (1'b1)
      (op[10:5] == 6'b000101),
      (op[10:5] == 6'b100101),
      (op == 11'b11010110000):
        dec_cls = C_B;
      (op[10:3] == 8'b10110100),
      (op[10:3] == 8'b10110101),
      (op[10:3] == 8'b01010100):
        dec_cls = C_CB;
      (op == 11'b11111000010),
      (op == 11'b11111000000):
        dec_cls = C_D;
      (op == 11'b10001011000),
      (op == 11'b11001011000),
      (op == 11'b10001010000),
      (op == 11'b10101010000),
      (op == 11'b11001010000),
      (op == 11'b10101011000),
      (op == 11'b11101011000),
      (op == 11'b11101010000),
      (op == 11'b11010011011),
      (op == 11'b11010011010):
        dec_cls = C_R;
      (op[10:1] == 10'b1001000100),
      (op[10:1] == 10'b1101000100),
      (op[10:1] == 10'b1011000100),
      (op[10:1] == 10'b1111000100),
      (op[10:1] == 10'b1001001000),
      (op[10:1] == 10'b1011001000),
      (op[10:1] == 10'b1101001000),
      (op[10:1] == 10'b1111001000):
        dec_cls = C_I;
      (op[10:2] == 9'b110100101),
      (op[10:2] == 9'b111100101):
        dec_cls = C_IW;
      default:
        dec_ill = 1'b1;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ir_q  <= '0;
      cls_q <= C_NONE;
    end else if (bus.ir_load) begin
      ir_q  <= bus.ir_data_in;
      cls_q <= dec_cls;
    end
  end

  // A new illegal load beats a simultaneous clear.
  always_ff @(posedge clock) begin
    if (reset)
      ill_q <= 1'b0;
    else if (bus.ir_load && dec_ill)
      ill_q <= 1'b1;
    else if (bus.illegal_clear)
      ill_q <= 1'b0;
    else if (!STICKY_ILL && bus.ir_load)
      ill_q <= 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset)
      flags_q <= FLAG_RST;
    else if (bus.flag_load)
      flags_q <= bus.alu_flags;
  end

  logic fv, fc, fn, fz;
  logic ge, gt, hi;
  logic bc;

  assign {fv, fc, fn, fz} = flags_q;
  assign ge = (fn == fv);
  assign gt = ~fz & ge;
  assign hi = fc & ~fz;

  always_comb begin
    bc = 1'b1;
    case (ir_q[3:0])
      4'h0: bc = fz;
      4'h1: bc = ~fz;
      4'h2: bc = fc;
      4'h3: bc = ~fc;
      4'h4: bc = fn;
      4'h5: bc = ~fn;
      4'h6: bc = fv;
      4'h7: bc = ~fv;
      4'h8: bc = hi;
      4'h9: bc = ~hi;
      4'hA: bc = ge;
      4'hB: bc = ~ge;
      4'hC: bc = gt;
      4'hD: bc = ~gt;
      default: bc = 1'b1;
    endcase
  end

  // Within class 5 the top byte separates CBZ/CBNZ from B.cond.
  always_comb begin
    bus.cond_met = 1'b0;
    if (cls_q == C_CB) begin
      if (ir_q[IW-1:IW-8] == 8'b10110100)
        bus.cond_met = bus.alu_zero;
      else if (ir_q[IW-1:IW-8] == 8'b10110101)
        bus.cond_met = ~bus.alu_zero;
      else
        bus.cond_met = bc;
    end
  end

  assign bus.instruction = ir_q;
  assign bus.instr_class = cls_q;
  assign bus.illegal     = ill_q;
  assign bus.status      = {flags_q, bus.alu_zero};

endmodule

// File: tb/tb_ir_status_decoder.sv
// Directed bench for ir_status_decoder: reset, class decode,
// sticky illegal, flag register and branch condition evaluation.
module tb_ir_status_decoder;
  logic clock;
  logic reset;
  int   n_run;
  int   n_fail;

  ir_status_decoder_if #(.IW(32)) bus ();

  ir_status_decoder #(
    .IW(32),
    .FLAG_RST(4'b0000),
    .STICKY_ILL(1'b1)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic ld(input logic [31:0] d);
    bus.ir_load    = 1'b1;
    bus.ir_data_in = d;
    step();
    bus.ir_load    = 1'b0;
  endtask

  task automatic fl(input logic [3:0] f);
    bus.flag_load = 1'b1;
    bus.alu_flags = f;
    step();
    bus.flag_load = 1'b0;
  endtask

  initial begin
    n_run  = 0;
    n_fail = 0;
    reset  = 1'b1;
    bus.ir_load       = 1'b1;
    bus.ir_data_in    = 32'hF84003E0;
    bus.flag_load     = 1'b1;
    bus.alu_flags     = 4'hF;
    bus.alu_zero      = 1'b0;
    bus.illegal_clear = 1'b0;
    step();
    reset         = 1'b0;
    bus.ir_load   = 1'b0;
    bus.flag_load = 1'b0;
    chk("rst_ir",   bus.instruction, 32'h0);
    chk("rst_cls",  32'(bus.instr_class), 32'd0);
    chk("rst_ill",  32'(bus.illegal), 32'd0);
    chk("rst_stat", 32'(bus.status), 32'h00);
    chk("rst_cond", 32'(bus.cond_met), 32'd0);

    ld(32'hF84003E0);
    chk("ldur_ir",  bus.instruction, 32'hF84003E0);
    chk("ldur_cls", 32'(bus.instr_class), 32'd1);
    ld(32'h8B020020);
    chk("add_cls",  32'(bus.instr_class), 32'd2);
    ld(32'h91000421);
    chk("addi_cls", 32'(bus.instr_class), 32'd3);
    ld(32'h14000004);
    chk("b_cls",    32'(bus.instr_class), 32'd4);
    chk("b_cond",   32'(bus.cond_met), 32'd0);
    ld(32'hD61F0000);
    chk("br_cls",   32'(bus.instr_class), 32'd4);
    ld(32'hD2800000);
    chk("movz_cls", 32'(bus.instr_class), 32'd6);
    ld(32'hD3600000);
    chk("lsl_cls",  32'(bus.instr_class), 32'd2);

    ld(32'hB4000040);
    chk("cbz_cls",  32'(bus.instr_class), 32'd5);
    bus.alu_zero = 1'b1;
    #1;
    chk("cbz_z1",   32'(bus.cond_met), 32'd1);
    chk("stat_az",  32'(bus.status), 32'h01);
    bus.alu_zero = 1'b0;
    #1;
    chk("cbz_z0",   32'(bus.cond_met), 32'd0);
    step();
    chk("hold_cls", 32'(bus.instr_class), 32'd5);
    chk("hold_ir",  bus.instruction, 32'hB4000040);
    ld(32'hB5000040);
    chk("cbnz_z0",  32'(bus.cond_met), 32'd1);

    fl(4'b0001);
    chk("stat_z",   32'(bus.status), 32'h02);
    ld(32'h54000040);
    chk("beq",      32'(bus.cond_met), 32'd1);
    ld(32'h54000041);
    chk("bne",      32'(bus.cond_met), 32'd0);
    ld(32'h5400004E);
    chk("bal",      32'(bus.cond_met), 32'd1);

    ld(32'h00000000);
    chk("ill_cls",  32'(bus.instr_class), 32'd0);
    chk("ill_set",  32'(bus.illegal), 32'd1);
    ld(32'h8B020020);
    chk("ill_cls2", 32'(bus.instr_class), 32'd2);
    chk("ill_hold", 32'(bus.illegal), 32'd1);
    bus.illegal_clear = 1'b1;
    step();
    bus.illegal_clear = 1'b0;
    chk("ill_clr",  32'(bus.illegal), 32'd0);
    bus.illegal_clear = 1'b1;
    ld(32'h00000000);
    bus.illegal_clear = 1'b0;
    chk("ill_win",  32'(bus.illegal), 32'd1);
    bus.illegal_clear = 1'b1;
    step();
    bus.illegal_clear = 1'b0;
    chk("ill_clr2", 32'(bus.illegal), 32'd0);

    ld(32'h5400004C);
    chk("bgt_old",  32'(bus.cond_met), 32'd0);
    bus.flag_load = 1'b1;
    bus.alu_flags = 4'b0000;
    #1;
    chk("bgt_pre",  32'(bus.cond_met), 32'd0);
    chk("stat_pre", 32'(bus.status), 32'h02);
    step();
    bus.flag_load = 1'b0;
    chk("bgt_new",  32'(bus.cond_met), 32'd1);
    ld(32'h5400004D);
    chk("ble",      32'(bus.cond_met), 32'd0);

    bus.ir_load    = 1'b1;
    bus.ir_data_in = 32'h54000048;
    bus.flag_load  = 1'b1;
    bus.alu_flags  = 4'b0100;
    step();
    bus.ir_load    = 1'b0;
    bus.flag_load  = 1'b0;
    chk("bhi_both", 32'(bus.cond_met), 32'd1);
    chk("stat_c",   32'(bus.status), 32'h08);
    ld(32'h54000049);
    chk("bls",      32'(bus.cond_met), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
